// File: rtl/reg_addr_demux_tmo.sv
// Register-bus demux with a runtime-programmable first-match address rule table and a response watchdog.
// Optional REG_DEMUX_ERR_CNT_EN adds err_cnt_o, a saturating count of error responses.
module reg_addr_demux_tmo #(
    parameter int unsigned NumSlaves     = 5,
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 1024,
    parameter logic [NumSlaves-1:0][2*AddrWidth-1:0] RstRules = '0,
    parameter logic [DataWidth-1:0] ErrData = DataWidth'(32'hBADCAB1E),
    localparam int unsigned StrbWidth = DataWidth / 8,
    localparam int unsigned IdxWidth  = (NumSlaves > 1) ? $clog2(NumSlaves) : 1,
    localparam int unsigned CntWidth  = $clog2(TimeoutCycles)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           in_valid_i,
    input  logic                           in_write_i,
    input  logic [AddrWidth-1:0]           in_addr_i,
    input  logic [DataWidth-1:0]           in_wdata_i,
    input  logic [StrbWidth-1:0]           in_wstrb_i,
    output logic                           in_ready_o,
    output logic [DataWidth-1:0]           in_rdata_o,
    output logic                           in_error_o,
    output logic [NumSlaves-1:0]           out_valid_o,
    output logic                           out_write_o,
    output logic [AddrWidth-1:0]           out_addr_o,
    output logic [DataWidth-1:0]           out_wdata_o,
    output logic [StrbWidth-1:0]           out_wstrb_o,
    input  logic [NumSlaves-1:0]           out_ready_i,
    input  logic [NumSlaves*DataWidth-1:0] out_rdata_i,
    input  logic [NumSlaves-1:0]           out_error_i,
    input  logic                           rule_we_i,
    input  logic [IdxWidth-1:0]            rule_idx_i,
    input  logic [AddrWidth-1:0]           rule_start_i,
    input  logic [AddrWidth-1:0]           rule_end_i,
    output logic [NumSlaves-1:0]           tmo_status_o,
    input  logic                           tmo_clr_i
`ifdef REG_DEMUX_ERR_CNT_EN
    ,
    output logic [15:0]                    err_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        ERR  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [IdxWidth-1:0]    sel_q, sel_d;
    logic                   write_q, write_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [StrbWidth-1:0]   wstrb_q, wstrb_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic [NumSlaves-1:0]   tmo_q, tmo_d;

    logic [AddrWidth-1:0]   rule_start_q [NumSlaves];
    logic [AddrWidth-1:0]   rule_end_q   [NumSlaves];

    logic                   hit;
    logic [IdxWidth-1:0]    hit_idx;
    logic [DataWidth-1:0]   rdata_arr [NumSlaves];
    logic                   sel_ready;
    logic                   sel_error;

    // First-match decode: scan from the top so the lowest matching index is left in hit_idx.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = int'(NumSlaves) - 1; i >= 0; i--) begin
            if ((in_addr_i >= rule_start_q[i]) && (in_addr_i < rule_end_q[i])) begin
                hit     = 1'b1;
                hit_idx = IdxWidth'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NumSlaves); i++) begin
            rdata_arr[i] = out_rdata_i[i*DataWidth +: DataWidth];
        end
    end

    assign sel_ready = out_ready_i[sel_q];
    assign sel_error = out_error_i[sel_q];

    // Rule table; an in-flight transaction only depends on the latched sel_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumSlaves); i++) begin
                rule_start_q[i] <= RstRules[i][2*AddrWidth-1:AddrWidth];
                rule_end_q[i]   <= RstRules[i][AddrWidth-1:0];
            end
        end else if (rule_we_i && (32'(rule_idx_i) < NumSlaves)) begin
            rule_start_q[rule_idx_i] <= rule_start_i;
            rule_end_q[rule_idx_i]   <= rule_end_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state and response; a timeout bit set in the same cycle as tmo_clr_i survives the clear.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_clr_i ? '0 : tmo_q;
        in_ready_o  = 1'b0;
        in_rdata_o  = '0;
        in_error_o  = 1'b0;
        out_valid_o = '0;

        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    sel_d   = hit_idx;
                    write_d = in_write_i;
                    addr_d  = in_addr_i;
                    wdata_d = in_wdata_i;
                    wstrb_d = in_wstrb_i;
                    cnt_d   = '0;
                    state_d = hit ? FWD : ERR;
                end
            end
            FWD: begin
                if (sel_ready) begin
                    out_valid_o[sel_q] = 1'b1;
                    in_ready_o         = 1'b1;
                    in_rdata_o         = rdata_arr[sel_q];
                    in_error_o         = sel_error;
                    cnt_d              = '0;
                    state_d            = IDLE;
                end else if (cnt_q == CntWidth'(TimeoutCycles - 1)) begin
                    in_ready_o         = 1'b1;
                    in_rdata_o         = ErrData;
                    in_error_o         = 1'b1;
                    tmo_d[sel_q]       = 1'b1;
                    cnt_d              = '0;
                    state_d            = IDLE;
                end else begin
                    out_valid_o[sel_q] = 1'b1;
                    cnt_d              = cnt_q + CntWidth'(1);
                end
            end
            ERR: begin
                in_ready_o = 1'b1;
                in_rdata_o = ErrData;
                in_error_o = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_write_o  = write_q;
    assign out_addr_o   = addr_q;
    assign out_wdata_o  = wdata_q;
    assign out_wstrb_o  = wstrb_q;
    assign tmo_status_o = tmo_q;

`ifdef REG_DEMUX_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_evt;

    // Saturating error counter; a clear coinciding with an error leaves a count of one.
    always_comb begin
        err_evt   = in_ready_o & in_error_o;
        err_cnt_d = err_cnt_q;
        if (tmo_clr_i) begin
            err_cnt_d = {15'd0, err_evt};
        end else if (err_evt && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_reg_addr_demux_tmo.sv
// Randomized self-checking bench for reg_addr_demux_tmo against a transaction-level reference model.
module tb_reg_addr_demux_tmo;

    localparam int unsigned NS  = 5;
    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned IW  = 3;
    localparam int unsigned TMO = 8;
    localparam logic [DW-1:0] ERR_DATA = 32'hBADCAB1E;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              in_valid_i;
    logic              in_write_i;
    logic [AW-1:0]     in_addr_i;
    logic [DW-1:0]     in_wdata_i;
    logic [SW-1:0]     in_wstrb_i;
    logic              in_ready_o;
    logic [DW-1:0]     in_rdata_o;
    logic              in_error_o;
    logic [NS-1:0]     out_valid_o;
    logic              out_write_o;
    logic [AW-1:0]     out_addr_o;
    logic [DW-1:0]     out_wdata_o;
    logic [SW-1:0]     out_wstrb_o;
    logic [NS-1:0]     out_ready_i;
    logic [NS*DW-1:0]  out_rdata_i;
    logic [NS-1:0]     out_error_i;
    logic              rule_we_i;
    logic [IW-1:0]     rule_idx_i;
    logic [AW-1:0]     rule_start_i;
    logic [AW-1:0]     rule_end_i;
    logic [NS-1:0]     tmo_status_o;
    logic              tmo_clr_i;
`ifdef REG_DEMUX_ERR_CNT_EN
    logic [15:0]       err_cnt_o;
`endif

    reg_addr_demux_tmo #(
        .NumSlaves    (NS),
        .AddrWidth    (AW),
        .DataWidth    (DW),
        .TimeoutCycles(TMO)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_valid_i   (in_valid_i),
        .in_write_i   (in_write_i),
        .in_addr_i    (in_addr_i),
        .in_wdata_i   (in_wdata_i),
        .in_wstrb_i   (in_wstrb_i),
        .in_ready_o   (in_ready_o),
        .in_rdata_o   (in_rdata_o),
        .in_error_o   (in_error_o),
        .out_valid_o  (out_valid_o),
        .out_write_o  (out_write_o),
        .out_addr_o   (out_addr_o),
        .out_wdata_o  (out_wdata_o),
        .out_wstrb_o  (out_wstrb_o),
        .out_ready_i  (out_ready_i),
        .out_rdata_i  (out_rdata_i),
        .out_error_i  (out_error_i),
        .rule_we_i    (rule_we_i),
        .rule_idx_i   (rule_idx_i),
        .rule_start_i (rule_start_i),
        .rule_end_i   (rule_end_i),
        .tmo_status_o (tmo_status_o),
        .tmo_clr_i    (tmo_clr_i)
`ifdef REG_DEMUX_ERR_CNT_EN
        ,
        .err_cnt_o    (err_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state
    logic [AW-1:0] m_start [NS];
    logic [AW-1:0] m_end   [NS];
    logic [NS-1:0] m_tmo;
    int            m_ecnt;

    int            rw_idx;
    logic [AW-1:0] rw_start;
    logic [AW-1:0] rw_end;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_decode(input logic [AW-1:0] a);
        for (int i = 0; i < int'(NS); i++) begin
            if (m_start[i] <= a && a < m_end[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NS); i++) begin
            m_start[i] = '0;
            m_end[i]   = '0;
        end
        m_tmo  = '0;
        m_ecnt = 0;
    endtask

    task automatic apply_rule(input int idx, input logic [AW-1:0] s, input logic [AW-1:0] e);
        if (idx >= 0 && idx < int'(NS)) begin
            m_start[idx] = s;
            m_end[idx]   = e;
        end
    endtask

    task automatic err_event(input logic clr);
        if (clr) m_ecnt = 1;
        else if (m_ecnt < 65535) m_ecnt++;
    endtask

    task automatic drive_slaves(input int sel, input logic rdy, input logic [DW-1:0] rd, input logic er);
        logic [NS-1:0] noise;
        noise = NS'($urandom);
        for (int i = 0; i < int'(NS); i++) begin
            out_rdata_i[i*DW +: DW] = $urandom;
            out_error_i[i]          = 1'($urandom_range(0, 1));
        end
        if (sel >= 0) begin
            noise[sel]                = rdy;
            out_rdata_i[sel*DW +: DW] = rd;
            out_error_i[sel]          = er;
        end
        out_ready_i = noise;
    endtask

    task automatic write_rule(input int idx, input logic [AW-1:0] s, input logic [AW-1:0] e);
        @(posedge clk_i); #1;
        tmo_clr_i    = 1'b0;
        in_valid_i   = 1'b0;
        rule_we_i    = 1'b1;
        rule_idx_i   = IW'(idx);
        rule_start_i = s;
        rule_end_i   = e;
        @(posedge clk_i); #1;
        rule_we_i = 1'b0;
        apply_rule(idx, s, e);
    endtask

    task automatic clear_tmo();
        @(posedge clk_i); #1;
        rule_we_i  = 1'b0;
        in_valid_i = 1'b0;
        tmo_clr_i  = 1'b1;
        @(posedge clk_i); #1;
        tmo_clr_i = 1'b0;
        m_tmo     = '0;
        m_ecnt    = 0;
        @(negedge clk_i);
        chk("tmo_after_clr", 64'(tmo_status_o), 64'(m_tmo));
    endtask

    // One transaction: rw_at=1 writes a rule in the request cycle, rw_at=2 in the first forward cycle.
    task automatic do_txn(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                          input logic [SW-1:0] ws, input int dly, input logic [DW-1:0] rd,
                          input logic er, input int rw_at, input logic clr_on_tmo);
        int            es;
        logic [NS-1:0] oh;
        logic          rdy;
        logic          clr;
        es = ref_decode(addr);
        oh = (es >= 0) ? (NS'(1) << es) : '0;

        @(posedge clk_i); #1;
        tmo_clr_i    = 1'b0;
        rule_we_i    = (rw_at == 1);
        rule_idx_i   = IW'(rw_idx);
        rule_start_i = rw_start;
        rule_end_i   = rw_end;
        in_valid_i   = 1'b1;
        in_write_i   = wr;
        in_addr_i    = addr;
        in_wdata_i   = wd;
        in_wstrb_i   = ws;
        drive_slaves(-1, 1'b0, '0, 1'b0);
        @(negedge clk_i);
        chk("idle_ready", 64'(in_ready_o), 64'd0);
        chk("idle_valid", 64'(out_valid_o), 64'd0);
        chk("tmo_status", 64'(tmo_status_o), 64'(m_tmo));
`ifdef REG_DEMUX_ERR_CNT_EN
        chk("err_cnt", 64'(err_cnt_o), 64'(m_ecnt));
`endif

        @(posedge clk_i); #1;
        if (rw_at == 1) apply_rule(rw_idx, rw_start, rw_end);
        rule_we_i  = 1'b0;
        in_valid_i = 1'b0;
        in_write_i = ~wr;
        in_addr_i  = {$urandom, $urandom};
        in_wdata_i = $urandom;
        in_wstrb_i = ~ws;

        if (es < 0) begin
            drive_slaves(-1, 1'b0, '0, 1'b0);
            @(negedge clk_i);
            chk("miss_ready", 64'(in_ready_o), 64'd1);
            chk("miss_error", 64'(in_error_o), 64'd1);
            chk("miss_rdata", 64'(in_rdata_o), 64'(ERR_DATA));
            chk("miss_valid", 64'(out_valid_o), 64'd0);
            err_event(1'b0);
        end else begin
            for (int k = 1; k <= int'(TMO); k++) begin
                if (k > 1) begin
                    @(posedge clk_i); #1;
                end
                rdy       = (k >= dly);
                clr       = clr_on_tmo && !rdy && (k == int'(TMO));
                rule_we_i = (rw_at == 2) && (k == 1);
                tmo_clr_i = clr;
                drive_slaves(es, rdy, rd, er);
                @(negedge clk_i);
                chk("fwd_addr", out_addr_o, addr);
                if (k == 1) begin
                    chk("fwd_write", 64'(out_write_o), 64'(wr));
                    chk("fwd_wdata", 64'(out_wdata_o), 64'(wd));
                    chk("fwd_wstrb", 64'(out_wstrb_o), 64'(ws));
                end
                if (rdy) begin
                    chk("rsp_ready", 64'(in_ready_o), 64'd1);
                    chk("rsp_valid", 64'(out_valid_o), 64'(oh));
                    chk("rsp_rdata", 64'(in_rdata_o), 64'(rd));
                    chk("rsp_error", 64'(in_error_o), 64'(er));
                    if (er) err_event(1'b0);
                    break;
                end else if (k == int'(TMO)) begin
                    chk("tmo_ready", 64'(in_ready_o), 64'd1);
                    chk("tmo_error", 64'(in_error_o), 64'd1);
                    chk("tmo_rdata", 64'(in_rdata_o), 64'(ERR_DATA));
                    chk("tmo_valid", 64'(out_valid_o), 64'd0);
                    if (clr) m_tmo = '0;
                    m_tmo[es] = 1'b1;
                    err_event(clr);
                end else begin
                    chk("wait_ready", 64'(in_ready_o), 64'd0);
                    chk("wait_valid", 64'(out_valid_o), 64'(oh));
                end
            end
            if (rw_at == 2) apply_rule(rw_idx, rw_start, rw_end);
        end
    endtask

    task automatic reset_mid_fwd();
        int            es;
        logic [NS-1:0] oh;
        write_rule(3, 64'h1002_0000, 64'h1002_1000);
        es = ref_decode(64'h1002_0040);
        oh = (es >= 0) ? (NS'(1) << es) : '0;
        @(posedge clk_i); #1;
        in_valid_i  = 1'b1;
        in_write_i  = 1'b0;
        in_addr_i   = 64'h1002_0040;
        out_ready_i = '0;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        #2;
        chk("prerst_valid", 64'(out_valid_o), 64'(oh));
        rst_ni = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_ready", 64'(in_ready_o), 64'd0);
        chk("rst_addr", out_addr_o, 64'd0);
        chk("rst_tmo", 64'(tmo_status_o), 64'd0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] addr;
        logic [AW-1:0] s;
        logic [AW-1:0] e;
        int            r;
        int            rwa;

        rst_ni       = 1'b0;
        in_valid_i   = 1'b0;
        in_write_i   = 1'b0;
        in_addr_i    = '0;
        in_wdata_i   = '0;
        in_wstrb_i   = '0;
        out_ready_i  = '0;
        out_rdata_i  = '0;
        out_error_i  = '0;
        rule_we_i    = 1'b0;
        rule_idx_i   = '0;
        rule_start_i = '0;
        rule_end_i   = '0;
        tmo_clr_i    = 1'b0;
        rw_idx       = 0;
        rw_start     = '0;
        rw_end       = '0;
        model_reset();

        #3;
        chk("reset_ready", 64'(in_ready_o), 64'd0);
        chk("reset_valid", 64'(out_valid_o), 64'd0);
        chk("reset_rdata", 64'(in_rdata_o), 64'd0);
        chk("reset_error", 64'(in_error_o), 64'd0);
        chk("reset_tmo", 64'(tmo_status_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // All rules disabled: decode error
        do_txn(64'h40, 1'b0, '0, '0, 1, 32'h0, 1'b0, 0, 1'b0);

        // Rule 3 hit, slave ready on second forward cycle
        write_rule(3, 64'h1002_0000, 64'h1002_1000);
        do_txn(64'h1002_0010, 1'b0, '0, 4'hF, 2, 32'h1234, 1'b0, 0, 1'b0);

        // Timeout on slave 1, then clear; then set-wins against a same-cycle clear
        write_rule(1, 64'h3000, 64'h4000);
        do_txn(64'h3000, 1'b0, '0, '0, 99, 32'h0, 1'b0, 0, 1'b0);
        clear_tmo();
        do_txn(64'h3FFF, 1'b1, 32'h55, 4'h1, 99, 32'h0, 1'b0, 0, 1'b1);
        clear_tmo();

        // Overlap priority and disable by end == start
        write_rule(0, 64'h2000, 64'h2100);
        write_rule(2, 64'h1F00, 64'h2800);
        do_txn(64'h2000, 1'b0, '0, '0, 1, 32'hA0A0, 1'b0, 0, 1'b0);
        write_rule(0, 64'h2000, 64'h2000);
        do_txn(64'h2000, 1'b0, '0, '0, 1, 32'hB0B0, 1'b0, 0, 1'b0);

        // Rewrite rule 2 while forwarding to slave 2
        rw_idx = 2; rw_start = 64'h5000; rw_end = 64'h6000;
        do_txn(64'h2004, 1'b0, '0, '0, 3, 32'hC0C0, 1'b0, 2, 1'b0);
        do_txn(64'h2004, 1'b0, '0, '0, 1, 32'h0, 1'b0, 0, 1'b0);
        do_txn(64'h5000, 1'b0, '0, '0, 1, 32'hD0D0, 1'b0, 0, 1'b0);

        // Write with partial strobes and a slave error
        do_txn(64'h5004, 1'b1, 32'hCAFE_F00D, 4'b0101, 1, 32'h0, 1'b1, 0, 1'b0);

        // Out-of-range rule index is ignored
        write_rule(7, 64'h0, 64'h1_0000);
        write_rule(5, 64'h0, 64'h1_0000);
        do_txn(64'h40, 1'b0, '0, '0, 1, 32'h0, 1'b0, 0, 1'b0);

        // Boundaries, full-width unsigned compares
        write_rule(4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        do_txn(64'h8000_0000_0000_0000, 1'b0, '0, '0, 1, 32'h4444, 1'b0, 0, 1'b0);
        do_txn(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, '0, '0, 1, 32'h0, 1'b0, 0, 1'b0);
        do_txn(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, '0, '0, 1, 32'h4545, 1'b0, 0, 1'b0);
        do_txn(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0, '0, 1, 32'h0, 1'b0, 0, 1'b0);
        do_txn(64'h1002_0FFF, 1'b0, '0, '0, 1, 32'h3333, 1'b0, 0, 1'b0);
        do_txn(64'h1002_1000, 1'b0, '0, '0, 1, 32'h0, 1'b0, 0, 1'b0);

        // Same-cycle rule write does not affect the decode it coincides with
        rw_idx = 3; rw_start = 64'h0; rw_end = 64'h0;
        do_txn(64'h1002_0020, 1'b0, '0, '0, 1, 32'h7777, 1'b0, 1, 1'b0);
        do_txn(64'h1002_0020, 1'b0, '0, '0, 1, 32'h0, 1'b0, 0, 1'b0);

        reset_mid_fwd();
        chk("post_rst_tmo", 64'(tmo_status_o), 64'd0);

        for (int i = 0; i < int'(NS); i++) begin
            s = 64'($urandom_range(0, 32'h8000));
            write_rule(i, s, s + 64'($urandom_range(32'h100, 32'h2000)));
        end

        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                s = 64'($urandom_range(0, 32'h8000));
                e = s + 64'($urandom_range(0, 32'h2000)) - 64'h200;
                write_rule(int'($urandom_range(0, 7)), s, e);
            end
            if ($urandom_range(0, 15) == 0) clear_tmo();
            r    = int'($urandom_range(0, NS - 1));
            addr = ($urandom_range(0, 1) == 1) ? m_start[r] : m_end[r];
            addr = addr + 64'($urandom_range(0, 4)) - 64'd2;
            if ($urandom_range(0, 9) == 0) addr = {$urandom, $urandom};
            rwa = int'($urandom_range(0, 4));
            if (rwa > 2) rwa = 0;
            rw_idx   = int'($urandom_range(0, 7));
            rw_start = 64'($urandom_range(0, 32'h8000));
            rw_end   = rw_start + 64'($urandom_range(0, 32'h2000)) - 64'h100;
            do_txn(addr, 1'($urandom_range(0, 1)), $urandom, SW'($urandom),
                   int'($urandom_range(1, 10)), $urandom, 1'($urandom_range(0, 1)),
                   rwa, ($urandom_range(0, 3) == 0));
        end

        @(posedge clk_i); #1;
        tmo_clr_i = 1'b0;
        rule_we_i = 1'b0;
        @(negedge clk_i);
        chk("final_tmo", 64'(tmo_status_o), 64'(m_tmo));
`ifdef REG_DEMUX_ERR_CNT_EN
        chk("final_err_cnt", 64'(err_cnt_o), 64'(m_ecnt));
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_addr_demux_tmo.md
Name: reg_addr_demux_tmo

Overview:
Register-bus demultiplexer with a runtime-reprogrammable address-rule table and a per-transaction response watchdog. It sits between the AXI-to-reg bridge and the peripheral register slaves (soc_ctrl, bootrom, fast_intr_ctrl, uart, external). It generalises the fixed compile-time RegMap with three additions:
- parametrised slave count,
- first-match rule priority with per-rule enable,
- decode-error and timeout error responses, so a hung or unmapped slave never stalls the bus.

Parameters:
NumSlaves, 5, number of downstream reg slaves (1..16)
AddrWidth, 64, address width
DataWidth, 32, data width; strobe width = DataWidth/8
TimeoutCycles, 1024, cycles a slave may withhold ready before abort (>=2)
RstRules, all-disabled, packed array [NumSlaves] of {start, end} reset contents of the rule table
ErrData, 32'hBADCAB1E, rdata returned on decode error or timeout

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
in_valid_i  in  1  master request valid
in_write_i  in  1  write=1 / read=0
in_addr_i  in  AddrWidth  request address
in_wdata_i  in  DataWidth  write data
in_wstrb_i  in  DataWidth/8  byte strobes
in_ready_o  out  1  response valid/accept pulse
in_rdata_o  out  DataWidth  read data
in_error_o  out  1  error response
out_valid_o  out  NumSlaves  one-hot per-slave valid
out_write_o  out  1  broadcast write
out_addr_o  out  AddrWidth  broadcast address
out_wdata_o  out  DataWidth  broadcast wdata
out_wstrb_o  out  DataWidth/8  broadcast wstrb
out_ready_i  in  NumSlaves  per-slave ready
out_rdata_i  in  NumSlaves*DataWidth  per-slave rdata
out_error_i  in  NumSlaves  per-slave error
rule_we_i  in  1  rule table write strobe
rule_idx_i  in  $clog2(NumSlaves)  rule to write
rule_start_i  in  AddrWidth  rule start (inclusive)
rule_end_i  in  AddrWidth  rule end (exclusive)
tmo_status_o  out  NumSlaves  sticky per-slave timeout flags
tmo_clr_i  in  1  clears tmo_status_o

Behaviour:
- Reset: FSM=IDLE; all outputs 0; rule table = RstRules; timeout counter 0; tmo_status_o 0.
- Rule match: start <= addr < end. A rule with end <= start is disabled. The lowest matching index wins. Comparisons are unsigned, full AddrWidth.
- FSM states are IDLE, FWD and ERR.
- IDLE:
  - On in_valid_i, decode and register: selected index, write, addr, wdata and wstrb.
  - On a hit, go to FWD; on a miss, go to ERR.
  - in_ready_o stays 0 in IDLE, so minimum latency is 2 cycles (request to ready).
- FWD:
  - out_valid_o[sel]=1 and the broadcast fields come from the captured registers.
  - When out_ready_i[sel]=1: in_ready_o=1 for that cycle, in_rdata_o=out_rdata_i[sel], in_error_o=out_error_i[sel]; next state IDLE; counter cleared.
  - Otherwise the counter increments. At TimeoutCycles-1 without ready: in_ready_o=1, in_error_o=1, in_rdata_o=ErrData; out_valid_o drops; tmo_status_o[sel] is set; next state IDLE.
- ERR: one cycle with in_ready_o=1, in_error_o=1, in_rdata_o=ErrData; next state IDLE.
- Back-to-back: a new request is accepted in the IDLE cycle that follows any response. Throughput is one transaction per 2 cycles minimum.
- Rule writes apply on the next clock edge. An in-flight transaction keeps its latched selection. A write to the same entry in the same cycle as an IDLE decode does not affect that decode (the old value is used).
- A rule_idx_i >= NumSlaves write is ignored.
- tmo_clr_i and a timeout on the same cycle: set wins.
- out_ready_i from non-selected slaves is ignored.
- Reset mid-FWD: outputs drop immediately (async). No response is issued.

Optional Feature:
REG_DEMUX_ERR_CNT_EN
- Enabled: adds output err_cnt_o [15:0], a saturating count of error responses (decode miss, timeout, or slave error). Reset 0. Holds at 16'hFFFF. Cleared by tmo_clr_i (clear and increment on the same cycle yield 1).
- Disabled: no port, no logic.

Test Plan:
- Rule 3 = {0x1002_0000, 0x1002_1000}; read 0x1002_0010; slave 3 ready on 2nd FWD cycle with rdata 0x1234 -> out_valid_o=5'b01000, in_ready_o at cycle 3, rdata 0x1234, error 0.
- Read 0x0000_0040 with all rules disabled -> ERR; in_ready_o=1 on cycle 2, error=1, rdata 0xBADCAB1E; no out_valid_o asserted.
- TimeoutCycles=8, slave 1 never ready -> error response after 8 FWD cycles with rdata ErrData; tmo_status_o=5'b00010; pulse tmo_clr_i -> 0.
- Overlapping rules 0 and 2 both cover 0x2000; request 0x2000 -> slave 0 selected. Disable rule 0 via rule_we_i (end=start), repeat -> slave 2 selected.
- Rewrite rule 2 while slave 2 is in FWD -> transaction completes to slave 2; next request decodes with the new rule.
- Write with wstrb 4'b0101, slave error=1 -> out_wstrb_o=4'b0101, in_error_o=1; with REG_DEMUX_ERR_CNT_EN, err_cnt_o increments to 1.
